// File: rtl/sdram_pkg.sv
// sdram_pkg: command codes shared with the controller core, error codes and init FSM states
package sdram_pkg;

    localparam logic [3:0] CMD_DESL  = 4'd0;
    localparam logic [3:0] CMD_NOP   = 4'd1;
    localparam logic [3:0] CMD_MRS   = 4'd2;
    localparam logic [3:0] CMD_ACT   = 4'd3;
    localparam logic [3:0] CMD_READ  = 4'd4;
    localparam logic [3:0] CMD_READA = 4'd5;
    localparam logic [3:0] CMD_WRIT  = 4'd6;
    localparam logic [3:0] CMD_WRITA = 4'd7;
    localparam logic [3:0] CMD_PRE   = 4'd8;
    localparam logic [3:0] CMD_PALL  = 4'd9;
    localparam logic [3:0] CMD_BST   = 4'd10;
    localparam logic [3:0] CMD_REF   = 4'd11;
    localparam logic [3:0] CMD_SELF  = 4'd12;
    localparam logic [3:0] CMD_SUP   = 4'd13;
    localparam logic [3:0] CMD_REC   = 4'd14;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_INIT      = 3'd1;
    localparam logic [2:0] ERR_ACT_OPEN  = 3'd2;
    localparam logic [2:0] ERR_CLOSED    = 3'd3;
    localparam logic [2:0] ERR_BANK_OPEN = 3'd4;
    localparam logic [2:0] ERR_TRCD      = 3'd5;
    localparam logic [2:0] ERR_TRP       = 3'd6;
    localparam logic [2:0] ERR_REF_LATE  = 3'd7;

    typedef enum logic [1:0] {R_POWER, R_REFS, R_READY} init_state_e;

endpackage

// File: rtl/sdram_rd_pipe.sv
// sdram_rd_pipe: CAS-latency read-return shift register, emptied by flush
module sdram_rd_pipe #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;

    always_comb begin
        valid_d[0] = in_valid && !flush;
        data_d[0]  = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1] && !flush;
            data_d[i]  = data_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/sdram_responder.sv
// sdram_responder: SDRAM device-side model; define SDRAM_RESP_TIMING_CHK_EN for tRCD/tRP/tRFC/refresh checks
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int NUM_BANK = 4,
    parameter int ROW_W    = 12,
    parameter int COL_W    = 9,
    parameter int DATA_W   = 16,
    parameter int MEM_AW   = 10,
    parameter int CAS_LAT  = 2,
    parameter int INIT_REF = 8,
    parameter int T_RCD    = 1,
    parameter int T_RP     = 1,
    parameter int T_RFC    = 3,
    parameter int REF_MAX  = 140
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [3:0]                               command,
    input  logic [$clog2(NUM_BANK)-1:0]              bank,
    input  logic [(ROW_W > COL_W ? ROW_W : COL_W)-1:0] addr,
    input  logic [DATA_W-1:0]                        wr_data,
    output logic [DATA_W-1:0]                        rd_data,
    output logic                                     rd_valid,
    output logic                                     init_done,
    output logic [NUM_BANK-1:0]                      bank_open,
    output logic                                     err,
    output logic [2:0]                               err_code
);

    localparam int BW  = $clog2(NUM_BANK);
    localparam int CIB = MEM_AW - 2 - BW;
    localparam int RIW = $clog2(INIT_REF + 1);

    init_state_e                 state_q, state_d;
    logic [RIW-1:0]              refs_q, refs_d;
    logic [NUM_BANK-1:0]         open_q, open_d;
    logic [NUM_BANK-1:0][1:0]    row_q, row_d;
    logic                        init_q, init_d, err_q, err_d;
    logic [2:0]                  code_q, code_d, viol;
    logic                        ready, exec, is_rd, is_wr, cur_open, pre_ok;
    logic                        t_rcd, t_rp, t_ref;
    logic [MEM_AW-1:0]           idx;
    logic [DATA_W-1:0]           mem [2**MEM_AW];

    always_comb begin
        ready    = state_q == R_READY;
        is_rd    = command == CMD_READ || command == CMD_READA;
        is_wr    = command == CMD_WRIT || command == CMD_WRITA;
        cur_open = open_q[bank];
        pre_ok   = command inside {CMD_DESL, CMD_NOP, CMD_PALL, CMD_REF} ||
                   (command == CMD_MRS && state_q == R_REFS && refs_q >= RIW'(INIT_REF));
        // lowest-numbered violation wins; codes 5-7 are advisory and the command still runs
        viol = (!ready && !pre_ok) ? ERR_INIT
             : (ready && command == CMD_ACT && cur_open) ? ERR_ACT_OPEN
             : (ready && (is_rd || is_wr) && !cur_open) ? ERR_CLOSED
             : (ready && (command == CMD_REF || command == CMD_MRS) && |open_q) ? ERR_BANK_OPEN
             : t_rcd ? ERR_TRCD
             : t_rp ? ERR_TRP
             : t_ref ? ERR_REF_LATE
             : ERR_NONE;
        exec = viol == ERR_NONE || viol >= ERR_TRCD;
    end

    always_comb begin
        state_d = state_q;
        refs_d  = refs_q;
        open_d  = open_q;
        row_d   = row_q;
        init_d  = init_q;
        if (exec && state_q == R_POWER && command == CMD_PALL) begin
            state_d = R_REFS;
            refs_d  = '0;
        end
        if (exec && state_q == R_REFS && command == CMD_REF && refs_q != '1)
            refs_d = refs_q + RIW'(1);
        if (exec && state_q == R_REFS && command == CMD_MRS) begin
            state_d = R_READY;
            init_d  = 1'b1;
        end
        if (exec && ready) begin
            if (command == CMD_ACT) begin
                open_d[bank] = 1'b1;
                row_d[bank]  = addr[1:0];
            end
            if (command inside {CMD_READA, CMD_WRITA, CMD_PRE})
                open_d[bank] = 1'b0;
            if (command == CMD_PALL)
                open_d = '0;
        end
        err_d  = viol != ERR_NONE;
        code_d = code_q == ERR_NONE ? viol : code_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= R_POWER;
            refs_q  <= '0;
            open_q  <= '0;
            row_q   <= '0;
            init_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            refs_q  <= refs_d;
            open_q  <= open_d;
            row_q   <= row_d;
            init_q  <= init_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    // only the low row bits reach the array; higher row/column bits alias
    assign idx = {bank, row_q[bank], addr[CIB-1:0]};

    always_ff @(posedge clk) begin
        if (exec && ready && is_wr)
            mem[idx] <= wr_data;
    end

    sdram_rd_pipe #(.DEPTH(CAS_LAT), .DATA_W(DATA_W)) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .flush    (exec && ready && command == CMD_BST),
        .in_valid (exec && ready && is_rd),
        .in_data  (mem[idx]),
        .out_valid(rd_valid),
        .out_data (rd_data)
    );

`ifdef SDRAM_RESP_TIMING_CHK_EN
    localparam int TMAX = T_RCD > T_RP ? (T_RCD > T_RFC ? T_RCD : T_RFC) : (T_RP > T_RFC ? T_RP : T_RFC);
    localparam int TW   = $clog2(TMAX + 1);
    localparam int CW   = $clog2(REF_MAX + 2);

    logic [NUM_BANK-1:0][TW-1:0] rcd_q, rcd_d, rp_q, rp_d;
    logic [TW-1:0]               rfc_q, rfc_d;
    logic [CW-1:0]               rage_q, rage_d;

    assign t_rcd = (is_rd || is_wr) && rcd_q[bank] != '0;
    assign t_rp  = (command == CMD_ACT && rp_q[bank] != '0) ||
                   (!(command inside {CMD_DESL, CMD_NOP} || command >= CMD_SELF) && rfc_q != '0);
    assign t_ref = ready && rage_q == CW'(REF_MAX + 1);

    // down-counters hold the cycles still blocked; the refresh age passes REF_MAX+1 once, then saturates
    always_comb begin
        for (int b = 0; b < NUM_BANK; b++) begin
            rcd_d[b] = exec && ready && command == CMD_ACT && bank == BW'(b) ? TW'(T_RCD - 1)
                     : rcd_q[b] - TW'(rcd_q[b] != '0);
            rp_d[b]  = exec && (command == CMD_PALL || (command == CMD_PRE && bank == BW'(b))) ? TW'(T_RP - 1)
                     : rp_q[b] - TW'(rp_q[b] != '0);
        end
        rfc_d  = exec && command == CMD_REF ? TW'(T_RFC - 1) : rfc_q - TW'(rfc_q != '0);
        rage_d = !ready || (exec && command == CMD_REF) ? '0 : rage_q + CW'(rage_q != '1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rcd_q  <= '0;
            rp_q   <= '0;
            rfc_q  <= '0;
            rage_q <= '0;
        end else begin
            rcd_q  <= rcd_d;
            rp_q   <= rp_d;
            rfc_q  <= rfc_d;
            rage_q <= rage_d;
        end
    end
`else
    assign t_rcd = 1'b0;
    assign t_rp  = 1'b0;
    assign t_ref = 1'b0;
`endif

    assign init_done = init_q;
    assign bank_open = open_q;
    assign err       = err_q;
    assign err_code  = code_q;

endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder: directed stimulus with a read-data scoreboard for sdram_responder
`timescale 1ns/1ps
module tb_sdram_responder;
    import sdram_pkg::*;

    localparam int CAS     = 2;
    localparam int REF_MAX = 140;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  command;
    logic [1:0]  bank;
    logic [11:0] addr;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        rd_valid, init_done, err;
    logic [3:0]  bank_open;
    logic [2:0]  err_code;

    sdram_responder dut (
        .clk(clk), .rst(rst), .command(command), .bank(bank), .addr(addr), .wr_data(wr_data),
        .rd_data(rd_data), .rd_valid(rd_valid), .init_done(init_done), .bank_open(bank_open),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int passed = 0, total = 0, err_cnt = 0;

    typedef struct { logic [15:0] data; int due; } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step(input logic [3:0] c, input logic [1:0] b = 2'd0,
                        input logic [11:0] a = 12'd0, input logic [15:0] d = 16'd0);
        command = c; bank = b; addr = a; wr_data = d;
        @(posedge clk); #1;
        command = CMD_NOP;
    endtask

    task automatic idle(input int n);
        repeat (n) step(CMD_NOP);
    endtask

    task automatic expect_rd(input logic [15:0] d);
        exp_t e;
        e.data = d;
        e.due  = cyc + CAS;
        sb.push_back(e);
    endtask

    task automatic rd(input logic [1:0] b, input logic [11:0] a, input logic [15:0] d);
        expect_rd(d);
        step(CMD_READ, b, a);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        chk("reset_outs", {rd_valid, init_done, bank_open, err, err_code}, 0);
        rst = 1'b0;
    endtask

    task automatic do_init();
        step(CMD_PALL);
        repeat (8) begin
            step(CMD_REF);
            idle(2);
        end
        step(CMD_MRS);
    endtask

    // monitor: every rd_valid must match the oldest expected read, on its due cycle
    always @(negedge clk) begin
        if (err) err_cnt++;
        if (rd_valid) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL rd_unexpected: got rd_valid=1 data %0h, expected rd_valid=0", rd_data);
            end else begin
                mon_e = sb.pop_front();
                chk("rd_data", rd_data, mon_e.data);
                chk("rd_cycle", cyc, mon_e.due);
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            total++;
            $display("FAIL rd_missing: got rd_valid=0 at cycle %0d, expected data %0h", cyc, sb[0].data);
            sb.delete(0);
        end
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish, expected finish before 50000ns");
        $fatal(1, "timeout");
    end

    int ref_k, ovd_n, ovd_cyc;

    initial begin
        command = CMD_NOP; bank = '0; addr = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {rd_valid, init_done, bank_open, err, err_code, rd_data}, 0);
        rst = 1'b0;

        step(CMD_PALL);
        repeat (8) begin
            step(CMD_REF);
            idle(2);
        end
        chk("init_before_mrs", init_done, 0);
        step(CMD_MRS);
        chk("init_done", init_done, 1);
        chk("init_err_pulses", err_cnt, 0);
        chk("init_err_code", err_code, 0);

        step(CMD_ACT, 2'd1, 12'd5);
        chk("bank_open_act", bank_open, 4'b0010);
        step(CMD_WRIT, 2'd1, 12'd3, 16'hBEEF);
        rd(2'd1, 12'd3, 16'hBEEF);
        step(CMD_WRIT, 2'd1, 12'd4, 16'h1234);
        rd(2'd1, 12'd3, 16'hBEEF);
        rd(2'd1, 12'd4, 16'h1234);
        step(CMD_WRIT, 2'd1, 12'd67, 16'hCAFE);
        rd(2'd1, 12'd3, 16'hCAFE);
        step(CMD_ACT, 2'd0, 12'd5);
        step(CMD_WRIT, 2'd0, 12'd3, 16'h0BAD);
        rd(2'd1, 12'd3, 16'hCAFE);
        rd(2'd0, 12'd3, 16'h0BAD);
        idle(4);
        chk("no_err_rw", err_cnt, 0);

        step(CMD_READ, 2'd2, 12'd3);
        chk("closed_err", err, 1);
        chk("closed_code", err_code, 3);
        idle(4);
        step(CMD_ACT, 2'd1, 12'd6);
        chk("act_open_err", err, 1);
        chk("code_sticky", err_code, 3);
        rd(2'd1, 12'd3, 16'hCAFE);

        step(CMD_READ, 2'd1, 12'd3);
        step(CMD_BST);
        idle(4);
        expect_rd(16'hCAFE);
        step(CMD_READA, 2'd1, 12'd3);
        chk("reada_close", bank_open, 4'b0001);
        rd(2'd0, 12'd3, 16'h0BAD);
        step(CMD_PALL);
        chk("pall_close", bank_open, 4'b0000);
        idle(4);

        do_reset();
        step(CMD_PALL);
        step(CMD_REF);
        step(CMD_MRS);
        chk("early_mrs_err", err, 1);
        chk("early_mrs_code", err_code, 1);
        chk("early_mrs_init", init_done, 0);
        idle(2);
        repeat (7) begin
            step(CMD_REF);
            idle(2);
        end
        step(CMD_MRS);
        chk("late_mrs_init", init_done, 1);
        chk("late_mrs_code", err_code, 1);

        do_reset();
        do_init();
        idle(2);
        ref_k = cyc;
        step(CMD_REF);
        ovd_n = 0;
        ovd_cyc = 0;
        repeat (200) begin
            step(CMD_NOP);
            if (err) begin
                if (ovd_n == 0) ovd_cyc = cyc;
                ovd_n++;
            end
        end
`ifdef SDRAM_RESP_TIMING_CHK_EN
        chk("overdue_pulses", ovd_n, 1);
        chk("overdue_cycle", ovd_cyc, ref_k + REF_MAX + 3);
        chk("overdue_code", err_code, 7);
`else
        chk("overdue_pulses", ovd_n, 0);
        chk("overdue_code", err_code, 0);
`endif

        do_reset();
        do_init();
        step(CMD_ACT, 2'd0, 12'd1);
        step(CMD_REF);
        chk("ref_open_err", err, 1);
        chk("ref_open_code", err_code, 4);
        chk("ref_open_bank", bank_open, 4'b0001);
        step(CMD_WRIT, 2'd0, 12'd2, 16'h5A5A);
        step(CMD_READ, 2'd0, 12'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_outs", {rd_valid, init_done, bank_open}, 0);
        rst = 1'b0;
        idle(4);

        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
